dm_axi_master: RTL and testbench

Data-memory bus master: accepts the MEM-stage data-memory request (chip select, byte write-enables, address, store data, output enable) and performs it as a single-beat AXI4 transaction. It stalls the pipeline through `o_mem_stall` until the transaction completes, and returns load data. It sits between the MEM stage and the AXI4 interconnect, and is the responder end of the stage's DM port.

---
 rtl/dm_axi_pkg.sv | 17 +
 rtl/axi_wr_track.sv | 49 ++++
 rtl/dm_axi_master.sv | 174 +++++++++++++++++
 tb/tb_dm_axi_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_axi_pkg.sv
// rtl/dm_axi_pkg.sv - shared types and AXI constants for the data-memory AXI master
package dm_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR,
        WR_B,
        DONE
    } state_t;

    localparam logic [2:0] AXI_SIZE_W     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_wr_track.sv
// rtl/axi_wr_track.sv - AW/W valid registers with per-channel completion flags
module axi_wr_track (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic aw_ready,
    input  logic w_ready,
    output logic aw_valid,
    output logic w_valid,
    output logic both_done
);

    logic aw_done;
    logic w_done;
    logic aw_hs;
    logic w_hs;

    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;

    // A channel counts as finished in the very cycle its handshake happens,
    // so the FSM can leave WR without an extra idle cycle.
    assign both_done = (aw_done || aw_hs) && (w_done || w_hs);

    // Raise both channels on start; each drops on its own handshake and remembers it.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else if (start) begin
            aw_valid <= 1'b1;
            w_valid  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_valid <= 1'b0;
                aw_done  <= 1'b1;
            end
            if (w_hs) begin
                w_valid <= 1'b0;
                w_done  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_axi_master.sv
// rtl/dm_axi_master.sv - MEM-stage data-memory port to single-beat AXI4 master (optional DM_AXI_ERR_EN)
module dm_axi_master #(
    parameter int ID_W      = 4,
    parameter int MASTER_ID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_DM_CS,
    input  logic            i_DM_OE,
    input  logic [3:0]      i_DM_WEB,
    input  logic [31:0]     i_DM_addr,
    input  logic [31:0]     i_DM_DI,
    output logic [31:0]     o_DM_DO,
    output logic            o_mem_stall,
    output logic            o_bus_err,
    output logic [ID_W-1:0] AWID,
    output logic [31:0]     AWADDR,
    output logic [7:0]      AWLEN,
    output logic [2:0]      AWSIZE,
    output logic [1:0]      AWBURST,
    output logic            AWVALID,
    input  logic            AWREADY,
    output logic [31:0]     WDATA,
    output logic [3:0]      WSTRB,
    output logic            WLAST,
    output logic            WVALID,
    input  logic            WREADY,
    input  logic [ID_W-1:0] BID,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY,
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [7:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY
);
    import dm_axi_pkg::*;

    state_t      state;
    state_t      next_state;
    logic        wr_req;
    logic        rd_req;
    logic        wr_start;
    logic        wr_both_done;
    logic        ar_valid_q;
    logic        r_ready_q;
    logic        b_ready_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        unused_ok;

    assign wr_req = i_DM_CS && (i_DM_WEB != 4'hF);
    assign rd_req = i_DM_CS && i_DM_OE && (i_DM_WEB == 4'hF);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode plus the pipeline stall and write-start strobe.
    always_comb begin
        next_state  = state;
        wr_start    = 1'b0;
        o_mem_stall = (wr_req || rd_req) && (state != DONE);
        case (state)
            IDLE: begin
                if (wr_req) begin
                    next_state = WR;
                    wr_start   = 1'b1;
                end else if (rd_req) begin
                    next_state = RD_A;
                end
            end
            RD_A:    if (ARREADY) next_state = RD_D;
            RD_D:    if (RVALID) next_state = DONE;
            WR:      if (wr_both_done) next_state = WR_B;
            WR_B:    if (BVALID) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake strobes are registered from the next state so no AXI output depends on an input combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
        end else begin
            ar_valid_q <= (next_state == RD_A);
            r_ready_q  <= (next_state == RD_D);
            b_ready_q  <= (next_state == WR_B);
        end
    end

    // Address and write data are sampled only in IDLE so they stay put while any VALID is high.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            addr_q  <= {i_DM_addr[31:2], 2'b00};
            wdata_q <= i_DM_DI;
            wstrb_q <= ~i_DM_WEB;
        end
    end

    // Load word holds the last completed read.
    always_ff @(posedge clk) begin
        if (rst)                          rdata_q <= 32'h0;
        else if (state == RD_D && RVALID) rdata_q <= RDATA;
    end

    axi_wr_track u_wr_track (
        .clk       (clk),
        .rst       (rst),
        .start     (wr_start),
        .aw_ready  (AWREADY),
        .w_ready   (WREADY),
        .aw_valid  (AWVALID),
        .w_valid   (WVALID),
        .both_done (wr_both_done)
    );

`ifdef DM_AXI_ERR_EN
    logic bus_err_q;

    // Sticky error on any non-OKAY response; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if ((state == RD_D && RVALID && RRESP != AXI_RESP_OKAY) ||
                     (state == WR_B && BVALID && BRESP != AXI_RESP_OKAY)) begin
            bus_err_q <= 1'b1;
        end
    end

    assign o_bus_err = bus_err_q;
`else
    assign o_bus_err = 1'b0;
`endif

    assign o_DM_DO = rdata_q;

    assign AWID    = ID_W'(MASTER_ID);
    assign AWADDR  = addr_q;
    assign AWLEN   = 8'd0;
    assign AWSIZE  = AXI_SIZE_W;
    assign AWBURST = AXI_BURST_INCR;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign BREADY  = b_ready_q;
    assign ARID    = ID_W'(MASTER_ID);
    assign ARADDR  = addr_q;
    assign ARLEN   = 8'd0;
    assign ARSIZE  = AXI_SIZE_W;
    assign ARBURST = AXI_BURST_INCR;
    assign ARVALID = ar_valid_q;
    assign RREADY  = r_ready_q;

    // IDs and RLAST carry no information for a single outstanding single-beat master.
    assign unused_ok = &{1'b0, BID, RID, RLAST, BRESP, RRESP};

endmodule

// File: tb/tb_dm_axi_master.sv
// tb/tb_dm_axi_master.sv - scoreboard bench for dm_axi_master with a delay-programmable AXI slave
module tb_dm_axi_master;

    localparam int ID_W      = 4;
    localparam int MASTER_ID = 1;

    typedef struct {
        int          kind;   // 0 none, 1 read, 2 write
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  web;
        logic        oe;
        int          d_a;    // AR or AW wait cycles
        int          d_w;    // W wait cycles
        int          d_b;    // R or B wait cycles
        logic [1:0]  resp;
    } txn_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_DM_CS, i_DM_OE;
    logic [3:0]      i_DM_WEB;
    logic [31:0]     i_DM_addr, i_DM_DI, o_DM_DO;
    logic            o_mem_stall, o_bus_err;
    logic [ID_W-1:0] AWID, ARID, BID, RID;
    logic [31:0]     AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]      AWLEN, ARLEN;
    logic [2:0]      AWSIZE, ARSIZE;
    logic [1:0]      AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]      WSTRB;
    logic            AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic            ARVALID, ARREADY, RLAST, RVALID, RREADY;

    txn_t exp_q[$];
    txn_t slave_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    dm_axi_master #(.ID_W(ID_W), .MASTER_ID(MASTER_ID)) dut (
        .clk(clk), .rst(rst),
        .i_DM_CS(i_DM_CS), .i_DM_OE(i_DM_OE), .i_DM_WEB(i_DM_WEB),
        .i_DM_addr(i_DM_addr), .i_DM_DI(i_DM_DI), .o_DM_DO(o_DM_DO),
        .o_mem_stall(o_mem_stall), .o_bus_err(o_bus_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- AXI slave: waits the programmed number of cycles per channel
    task automatic slave_clear();
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
    endtask

    initial begin
        txn_t t;
        bit ab, ok, aw_ok, w_ok;
        int cnt, aw_cnt, w_cnt;
        slave_clear();
        BID = '0; RID = '0; BRESP = 2'b00; RRESP = 2'b00; RLAST = 1'b1; RDATA = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (slave_q.size() != 0) begin
                t = slave_q.pop_front();
                ab = 0;
                if (t.kind == 1) begin
                    ok = 0; cnt = 0;
                    while (!ok && !ab) begin
                        @(posedge clk); #2;
                        ARREADY = 1'b0;
                        if (rst) ab = 1;
                        else if (ARVALID) begin
                            if (cnt == t.d_a) begin ARREADY = 1'b1; ok = 1; end
                            else cnt++;
                        end
                    end
                    ok = 0; cnt = 0;
                    while (!ok && !ab) begin
                        @(posedge clk); #2;
                        ARREADY = 1'b0;
                        if (rst) ab = 1;
                        else if (RREADY) begin
                            if (cnt == t.d_b) begin
                                RVALID = 1'b1; RDATA = t.data; RRESP = t.resp; ok = 1;
                            end else cnt++;
                        end
                    end
                end else begin
                    aw_ok = 0; w_ok = 0; aw_cnt = 0; w_cnt = 0;
                    while (!(aw_ok && w_ok) && !ab) begin
                        @(posedge clk); #2;
                        AWREADY = 1'b0; WREADY = 1'b0;
                        if (rst) ab = 1;
                        else begin
                            if (AWVALID && !aw_ok) begin
                                if (aw_cnt == t.d_a) begin AWREADY = 1'b1; aw_ok = 1; end
                                else aw_cnt++;
                            end
                            if (WVALID && !w_ok) begin
                                if (w_cnt == t.d_w) begin WREADY = 1'b1; w_ok = 1; end
                                else w_cnt++;
                            end
                        end
                    end
                    ok = 0; cnt = 0;
                    while (!ok && !ab) begin
                        @(posedge clk); #2;
                        AWREADY = 1'b0; WREADY = 1'b0;
                        if (rst) ab = 1;
                        else if (BREADY) begin
                            if (cnt == t.d_b) begin BVALID = 1'b1; BRESP = t.resp; ok = 1; end
                            else cnt++;
                        end
                    end
                end
                if (!ab) begin @(posedge clk); #2; end
                slave_clear();
                RDATA = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard
    txn_t        cur;
    bit          active = 0;
    int          stall_n, aw_n, w_n, b_n, ar_n, r_n, exp_stall;
    logic [31:0] model_do = 32'h0;
    logic        model_err = 1'b0;
    logic        wr_req, rd_req;

    always begin
        @(negedge clk);
        if (rst) begin
            active = 0; model_do = 32'h0; model_err = 1'b0;
        end else begin
            wr_req = i_DM_CS && (i_DM_WEB != 4'hF);
            rd_req = i_DM_CS && i_DM_OE && (i_DM_WEB == 4'hF);
            if (i_DM_CS && !wr_req && !rd_req) chk("none_stall", o_mem_stall, 0);
            if (!active && (wr_req || rd_req)) begin
                if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    cur = exp_q.pop_front();
                    active = 1; stall_n = 0; aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
                end
            end
            if (!active) chk("idle_valids", {AWVALID, WVALID, ARVALID}, 0);
            if (active) begin
                if (o_mem_stall) stall_n++;
                if (aw_n > 0) chk("aw_dropped", AWVALID, 0);
                if (w_n > 0)  chk("w_dropped", WVALID, 0);
                if (ar_n > 0) chk("ar_dropped", ARVALID, 0);
                if (AWVALID && AWREADY) begin
                    aw_n++;
                    chk("awaddr", AWADDR, cur.addr & 32'hFFFF_FFFC);
                    chk("aw_fixed", {AWID, AWLEN, AWSIZE, AWBURST}, {4'(MASTER_ID), 8'd0, 3'b010, 2'b01});
                end
                if (WVALID && WREADY) begin
                    w_n++;
                    chk("wdata", WDATA, cur.data);
                    chk("wstrb_wlast", {WSTRB, WLAST}, {~cur.web, 1'b1});
                end
                if (ARVALID && ARREADY) begin
                    ar_n++;
                    chk("araddr", ARADDR, cur.addr & 32'hFFFF_FFFC);
                    chk("ar_fixed", {ARID, ARLEN, ARSIZE, ARBURST}, {4'(MASTER_ID), 8'd0, 3'b010, 2'b01});
                end
                if (BVALID && BREADY) b_n++;
                if (RVALID && RREADY) r_n++;
                if (!o_mem_stall) begin
                    if (cur.kind == 1) begin
                        exp_stall = 3 + cur.d_a + cur.d_b;
                        chk("rd_beats", {ar_n[7:0], r_n[7:0]}, 16'h0101);
                        model_do = cur.data;
                    end else begin
                        exp_stall = 3 + ((cur.d_a > cur.d_w) ? cur.d_a : cur.d_w) + cur.d_b;
                        chk("wr_beats", {aw_n[7:0], w_n[7:0], b_n[7:0]}, 24'h010101);
                    end
                    chk("stall_cycles", stall_n, exp_stall);
`ifdef DM_AXI_ERR_EN
                    if (cur.resp != 2'b00) model_err = 1'b1;
`endif
                    chk("bus_err", o_bus_err, model_err);
                    active = 0;
                end
            end
            chk("load_word", o_DM_DO, model_do);
        end
    end

    // ---------------- stimulus
    task automatic drive(input txn_t t);
        i_DM_CS = 1'b1; i_DM_OE = t.oe; i_DM_WEB = t.web;
        i_DM_addr = t.addr; i_DM_DI = t.data;
    endtask

    task automatic do_txn(input txn_t t);
        int n;
        @(posedge clk); #1;
        drive(t);
        if (t.kind == 0) begin
            @(negedge clk);
        end else begin
            exp_q.push_back(t);
            slave_q.push_back(t);
            for (n = 0; n < 300; n++) begin
                @(negedge clk);
                if (!o_mem_stall) break;
            end
            chk("completes_in_time", n < 300, 1);
        end
        @(posedge clk); #1;
        i_DM_CS = 1'b0;
    endtask

    function automatic txn_t mk(input int kind, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] web, input int d_a, input int d_w, input int d_b,
                                input logic [1:0] resp);
        txn_t t;
        t.kind = kind; t.addr = addr; t.data = data; t.d_a = d_a; t.d_w = d_w; t.d_b = d_b;
        t.resp = resp;
        t.web  = (kind == 2) ? web : 4'hF;
        t.oe   = (kind == 1);
        return t;
    endfunction

    initial begin
        txn_t t;
        int   n;
        rst = 1'b1;
        i_DM_CS = 1'b0; i_DM_OE = 1'b0; i_DM_WEB = 4'hF; i_DM_addr = 32'h0; i_DM_DI = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
        chk("rst_do", o_DM_DO, 0);
        chk("rst_err", o_bus_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_txn(mk(1, 32'h0000_1006, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00));
        do_txn(mk(2, 32'h0000_2000, 32'h0000_ABCD, 4'b1100, 0, 0, 2, 2'b00));
        do_txn(mk(2, 32'h0000_2004, 32'h1234_5678, 4'b0000, 2, 0, 0, 2'b00));
        do_txn(mk(2, 32'h0000_2008, 32'h8765_4321, 4'b0111, 0, 3, 1, 2'b00));
        do_txn(mk(1, 32'h0000_300B, 32'hCAFE_F00D, 4'hF, 0, 0, 4, 2'b00));
        do_txn(mk(0, 32'h0000_4000, 32'h0, 4'hF, 0, 0, 0, 2'b00));

        // Reset while the read is waiting for data.
        t = mk(1, 32'h0000_5000, 32'h5555_AAAA, 4'hF, 0, 0, 20, 2'b00);
        @(posedge clk); #1;
        drive(t);
        exp_q.push_back(t);
        slave_q.push_back(t);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (RREADY) break;
        end
        chk("reached_rd_data", n < 50, 1);
        @(posedge clk); #1;
        rst = 1'b1; i_DM_CS = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
        chk("abort_do", o_DM_DO, 0);
        chk("abort_stall", o_mem_stall, 0);
        do_txn(mk(1, 32'h0000_5004, 32'h0BAD_F00D, 4'hF, 1, 0, 1, 2'b00));

        // Error response followed by clean traffic: the flag must stick when enabled.
        do_txn(mk(2, 32'h0000_6000, 32'hFFFF_0000, 4'b0011, 0, 0, 0, 2'b10));
        do_txn(mk(1, 32'h0000_6004, 32'h1111_2222, 4'hF, 0, 0, 0, 2'b00));
        do_txn(mk(2, 32'h0000_6008, 32'h3333_4444, 4'b1110, 1, 1, 0, 2'b00));

        for (int i = 0; i < 80; i++) begin
            int k;
            k = $urandom_range(0, 9);
            t = mk((k == 0) ? 0 : (k < 5) ? 1 : 2, $urandom, $urandom, 4'($urandom_range(0, 14)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
            if (t.kind == 2) t.oe = 1'($urandom_range(0, 1));
            do_txn(t);
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
